// File: rtl/seat_req_arbiter_if.sv
// Kiosk/manager request bus and seat-memory write bus shared by the arbiter
// and whatever drives the requests.
interface seat_req_arbiter_if;
    logic [3:0]        kreq_arb;
    logic [3:0][31:0]  kstu_arb;
    logic [3:0][4:0]   kseat_arb;
    logic [3:0][1:0]   kstate_arb;
    logic [3:0]        kack_arb;
    logic              mreq_arb;
    logic [1:0]        mop_arb;
    logic [1:0]        mban_arb;
    logic [10:0]       mlimit_arb;
    logic              mack_arb;
    logic              write_mem;
    logic [31:0]       Student_No_mem;
    logic [4:0]        Seat_No_mem;
    logic [1:0]        Seat_State_mem;
    logic [1:0]        write_set_mem;
    logic [1:0]        ban_mem;
    logic [10:0]       limit_time_mem;
    logic              rst_mem;
    logic [10:0]       Time_mem;

    modport master (
        output kreq_arb, kstu_arb, kseat_arb, kstate_arb,
        output mreq_arb, mop_arb, mban_arb, mlimit_arb,
        input  kack_arb, mack_arb,
        input  write_mem, Student_No_mem, Seat_No_mem, Seat_State_mem,
        input  write_set_mem, ban_mem, limit_time_mem, rst_mem, Time_mem
    );

    modport slave (
        input  kreq_arb, kstu_arb, kseat_arb, kstate_arb,
        input  mreq_arb, mop_arb, mban_arb, mlimit_arb,
        output kack_arb, mack_arb,
        output write_mem, Student_No_mem, Seat_No_mem, Seat_State_mem,
        output write_set_mem, ban_mem, limit_time_mem, rst_mem, Time_mem
    );
endinterface

// File: rtl/seat_req_arbiter.sv
// Arbitrates four seat kiosks and one manager onto a single seat-memory write
// port, and keeps the minute-of-day clock with its daily opening reset.
module seat_req_arbiter #(
    parameter int TICKS_PER_MIN = 60,
    parameter int OPEN_MIN      = 360
) (
    input  logic               clk_arb,
    input  logic               rst_n_arb,
    seat_req_arbiter_if.slave  bus
);

    localparam int             CW        = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
    localparam logic [CW-1:0]  TICK_LAST = CW'(TICKS_PER_MIN - 1);
    localparam logic [10:0]    OPEN_T    = 11'(OPEN_MIN);
    localparam logic [10:0]    LAST_MIN  = 11'd1439;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, RELEASE} state_t;

    logic [CW-1:0] tick_cnt;
    logic [10:0]   next_min;
    logic          open_hit;
    logic          open_hit_d;

    state_t        state;
    logic [1:0]    rr_ptr;
    logic          grant_mgr;
    logic [1:0]    win_idx;
    logic [1:0]    op_q;

    logic          k_found;
    logic [1:0]    k_idx;
    logic [1:0]    scan_idx;

    always_comb begin
        next_min = (bus.Time_mem == LAST_MIN) ? 11'd0 : bus.Time_mem + 11'd1;
    end

    // open_hit marks the tick that lands on OPEN_MIN; rst_mem follows for two cycles
    always_ff @(posedge clk_arb or negedge rst_n_arb) begin
        if (!rst_n_arb) begin
            tick_cnt     <= '0;
            bus.Time_mem <= OPEN_T;
            open_hit     <= 1'b0;
            open_hit_d   <= 1'b0;
            bus.rst_mem  <= 1'b0;
        end else begin
            open_hit <= 1'b0;
            if (tick_cnt == TICK_LAST) begin
                tick_cnt     <= '0;
                bus.Time_mem <= next_min;
                open_hit     <= (next_min == OPEN_T);
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
            open_hit_d  <= open_hit;
            bus.rst_mem <= open_hit | open_hit_d;
        end
    end

    // Round-robin scan starting at the kiosk after the last kiosk winner
    always_comb begin
        k_found  = 1'b0;
        k_idx    = rr_ptr;
        scan_idx = rr_ptr;
        for (int i = 0; i < 4; i++) begin
            scan_idx = rr_ptr + 2'(i);
            if (!k_found && bus.kreq_arb[scan_idx]) begin
                k_found = 1'b1;
                k_idx   = scan_idx;
            end
        end
    end

    always_ff @(posedge clk_arb or negedge rst_n_arb) begin
        if (!rst_n_arb) begin
            state              <= IDLE;
            rr_ptr             <= 2'd0;
            grant_mgr          <= 1'b0;
            win_idx            <= 2'd0;
            op_q               <= 2'd0;
            bus.write_mem      <= 1'b0;
            bus.write_set_mem  <= 2'd0;
            bus.kack_arb       <= 4'd0;
            bus.mack_arb       <= 1'b0;
            bus.Student_No_mem <= 32'd0;
            bus.Seat_No_mem    <= 5'd0;
            bus.Seat_State_mem <= 2'd0;
            bus.ban_mem        <= 2'd2;
            bus.limit_time_mem <= 11'd120;
        end else begin
            bus.write_mem     <= 1'b0;
            bus.write_set_mem <= 2'd0;
            bus.kack_arb      <= 4'd0;
            bus.mack_arb      <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.rst_mem) begin
                        if (bus.mreq_arb) begin
                            grant_mgr          <= 1'b1;
                            op_q               <= bus.mop_arb;
                            bus.ban_mem        <= bus.mban_arb;
                            bus.limit_time_mem <= bus.mlimit_arb;
                            state              <= SETUP;
                        end else if (k_found) begin
                            grant_mgr          <= 1'b0;
                            win_idx            <= k_idx;
                            rr_ptr             <= k_idx + 2'd1;
                            bus.Student_No_mem <= bus.kstu_arb[k_idx];
                            bus.Seat_No_mem    <= bus.kseat_arb[k_idx];
                            bus.Seat_State_mem <= bus.kstate_arb[k_idx];
                            state              <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    state <= STROBE;
                    if (grant_mgr) begin
                        // Opcodes 0 and 3 are not memory commands: acked without a strobe
                        if (op_q == 2'd1 || op_q == 2'd2)
                            bus.write_set_mem <= op_q;
                    end else begin
                        bus.write_mem <= 1'b1;
                    end
                end
                STROBE: begin
                    state <= RELEASE;
                    if (grant_mgr)
                        bus.mack_arb <= 1'b1;
                    else
                        bus.kack_arb <= 4'b0001 << win_idx;
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seat_req_arbiter.sv
// Directed bench for seat_req_arbiter: kiosk/manager sequencing, round-robin
// order, daily clock wrap with the opening reset, and asynchronous reset.
module tb_seat_req_arbiter;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    seat_req_arbiter_if bus();

    seat_req_arbiter #(.TICKS_PER_MIN(4), .OPEN_MIN(360)) dut (
        .clk_arb   (clk),
        .rst_n_arb (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs;
        bus.kreq_arb   = 4'd0;
        bus.kstu_arb   = '0;
        bus.kseat_arb  = '0;
        bus.kstate_arb = '0;
        bus.mreq_arb   = 1'b0;
        bus.mop_arb    = 2'd0;
        bus.mban_arb   = 2'd0;
        bus.mlimit_arb = 11'd0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        clear_inputs();
        bus.kreq_arb = 4'hF;
        bus.mreq_arb = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.write_mem !== 1'b0) begin n_bad++; $display("FAIL rst_write_mem got %0h want 0", bus.write_mem); end
        n_cmp++; if (bus.write_set_mem !== 2'd0) begin n_bad++; $display("FAIL rst_write_set got %0h want 0", bus.write_set_mem); end
        n_cmp++; if (bus.kack_arb !== 4'd0 || bus.mack_arb !== 1'b0) begin n_bad++; $display("FAIL rst_acks got %0h/%0h want 0/0", bus.kack_arb, bus.mack_arb); end
        n_cmp++; if (bus.rst_mem !== 1'b0) begin n_bad++; $display("FAIL rst_rst_mem got %0h want 0", bus.rst_mem); end
        n_cmp++; if (bus.Student_No_mem !== 32'd0 || bus.Seat_No_mem !== 5'd0 || bus.Seat_State_mem !== 2'd0) begin
            n_bad++; $display("FAIL rst_kiosk_payload got %0h/%0h/%0h want 0/0/0", bus.Student_No_mem, bus.Seat_No_mem, bus.Seat_State_mem); end
        n_cmp++; if (bus.ban_mem !== 2'd2) begin n_bad++; $display("FAIL rst_ban got %0d want 2", bus.ban_mem); end
        n_cmp++; if (bus.limit_time_mem !== 11'd120) begin n_bad++; $display("FAIL rst_limit got %0d want 120", bus.limit_time_mem); end
        n_cmp++; if (bus.Time_mem !== 11'd360) begin n_bad++; $display("FAIL rst_time got %0d want 360", bus.Time_mem); end
        clear_inputs();
    endtask

    task automatic test_single_kiosk;
        do_reset();
        bus.kreq_arb[2]   = 1'b1;
        bus.kstu_arb[2]   = 32'd20230001;
        bus.kseat_arb[2]  = 5'd5;
        bus.kstate_arb[2] = 2'd2;
        step();
        n_cmp++; if (bus.write_mem !== 1'b0 || bus.Student_No_mem !== 32'd20230001) begin
            n_bad++; $display("FAIL single_setup got wr=%0h stu=%0d want wr=0 stu=20230001", bus.write_mem, bus.Student_No_mem); end
        step();
        n_cmp++; if (bus.write_mem !== 1'b1 || bus.Seat_No_mem !== 5'd5 || bus.Seat_State_mem !== 2'd2 || bus.Student_No_mem !== 32'd20230001) begin
            n_bad++; $display("FAIL single_strobe got wr=%0h seat=%0d st=%0d stu=%0d want 1/5/2/20230001",
                              bus.write_mem, bus.Seat_No_mem, bus.Seat_State_mem, bus.Student_No_mem); end
        n_cmp++; if (bus.kack_arb !== 4'd0) begin n_bad++; $display("FAIL single_early_ack got %0h want 0", bus.kack_arb); end
        step();
        n_cmp++; if (bus.kack_arb !== 4'b0100 || bus.write_mem !== 1'b0) begin
            n_bad++; $display("FAIL single_ack got ack=%0h wr=%0h want 4/0", bus.kack_arb, bus.write_mem); end
        bus.kreq_arb[2] = 1'b0;
        step();
        n_cmp++; if (bus.kack_arb !== 4'd0 || bus.Seat_No_mem !== 5'd5) begin
            n_bad++; $display("FAIL single_after got ack=%0h seat=%0d want 0/5", bus.kack_arb, bus.Seat_No_mem); end
    endtask

    task automatic test_contention;
        int        sk [5];
        logic [31:0] sv [5];
        int        n;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.kstu_arb[i]  = 32'(100 + i);
            bus.kseat_arb[i] = 5'(i);
        end
        bus.kreq_arb = 4'hF;
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (bus.write_mem === 1'b1 && n < 5) begin
                sk[n] = k;
                sv[n] = bus.Student_No_mem;
                n++;
            end
        end
        bus.kreq_arb = 4'h0;
        n_cmp++; if (n !== 5) begin n_bad++; $display("FAIL cont_strobes got %0d want 5", n); end
        for (int i = 0; i < 5; i++) begin
            if (i < n) begin
                n_cmp++; if (sv[i] !== 32'(100 + (i % 4))) begin n_bad++; $display("FAIL cont_order[%0d] got %0d want %0d", i, sv[i], 100 + (i % 4)); end
                n_cmp++; if (sk[i] !== 2 + 4 * i) begin n_bad++; $display("FAIL cont_cycle[%0d] got %0d want %0d", i, sk[i], 2 + 4 * i); end
            end
        end
        repeat (4) step();
    endtask

    task automatic test_manager_priority;
        do_reset();
        bus.mreq_arb    = 1'b1;
        bus.mop_arb     = 2'd1;
        bus.mban_arb    = 2'd0;
        bus.mlimit_arb  = 11'd77;
        bus.kreq_arb[1] = 1'b1;
        bus.kstu_arb[1] = 32'd555;
        step();
        step();
        n_cmp++; if (bus.write_set_mem !== 2'd1 || bus.ban_mem !== 2'd0 || bus.write_mem !== 1'b0) begin
            n_bad++; $display("FAIL mgr_strobe got set=%0d ban=%0d wr=%0h want 1/0/0", bus.write_set_mem, bus.ban_mem, bus.write_mem); end
        n_cmp++; if (bus.limit_time_mem !== 11'd77) begin n_bad++; $display("FAIL mgr_limit got %0d want 77", bus.limit_time_mem); end
        step();
        n_cmp++; if (bus.mack_arb !== 1'b1 || bus.write_set_mem !== 2'd0 || bus.kack_arb !== 4'd0) begin
            n_bad++; $display("FAIL mgr_ack got mack=%0h set=%0d kack=%0h want 1/0/0", bus.mack_arb, bus.write_set_mem, bus.kack_arb); end
        bus.mreq_arb = 1'b0;
        repeat (3) step();
        n_cmp++; if (bus.write_mem !== 1'b1 || bus.Student_No_mem !== 32'd555 || bus.ban_mem !== 2'd0) begin
            n_bad++; $display("FAIL mgr_then_kiosk got wr=%0h stu=%0d ban=%0d want 1/555/0", bus.write_mem, bus.Student_No_mem, bus.ban_mem); end
        step();
        n_cmp++; if (bus.kack_arb !== 4'b0010 || bus.mack_arb !== 1'b0) begin
            n_bad++; $display("FAIL mgr_kiosk_ack got kack=%0h mack=%0h want 2/0", bus.kack_arb, bus.mack_arb); end
        bus.kreq_arb[1] = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_bad_op;
        do_reset();
        bus.mreq_arb   = 1'b1;
        bus.mop_arb    = 2'd3;
        bus.mban_arb   = 2'd1;
        bus.mlimit_arb = 11'd30;
        step();
        step();
        n_cmp++; if (bus.write_set_mem !== 2'd0 || bus.write_mem !== 1'b0) begin
            n_bad++; $display("FAIL badop_strobe got set=%0d wr=%0h want 0/0", bus.write_set_mem, bus.write_mem); end
        step();
        n_cmp++; if (bus.mack_arb !== 1'b1) begin n_bad++; $display("FAIL badop_ack got %0h want 1", bus.mack_arb); end
        bus.mreq_arb = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_drop_after_grant;
        do_reset();
        bus.kreq_arb[0] = 1'b1;
        bus.kstu_arb[0] = 32'd42;
        step();
        bus.kreq_arb[0] = 1'b0;
        step();
        n_cmp++; if (bus.write_mem !== 1'b1 || bus.Student_No_mem !== 32'd42) begin
            n_bad++; $display("FAIL drop_strobe got wr=%0h stu=%0d want 1/42", bus.write_mem, bus.Student_No_mem); end
        step();
        n_cmp++; if (bus.kack_arb !== 4'b0001) begin n_bad++; $display("FAIL drop_ack got %0h want 1", bus.kack_arb); end
        repeat (2) step();
    endtask

    task automatic test_async_reset;
        int extra;
        do_reset();
        bus.kreq_arb[1]   = 1'b1;
        bus.kstu_arb[1]   = 32'd9;
        bus.kseat_arb[1]  = 5'd3;
        bus.kstate_arb[1] = 2'd1;
        step();
        step();
        n_cmp++; if (bus.write_mem !== 1'b1) begin n_bad++; $display("FAIL areset_pre got wr=%0h want 1", bus.write_mem); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.write_mem !== 1'b0 || bus.kack_arb !== 4'd0 || bus.mack_arb !== 1'b0) begin
            n_bad++; $display("FAIL areset_ctrl got wr=%0h kack=%0h mack=%0h want 0/0/0", bus.write_mem, bus.kack_arb, bus.mack_arb); end
        n_cmp++; if (bus.Student_No_mem !== 32'd0 || bus.Seat_No_mem !== 5'd0 || bus.ban_mem !== 2'd2 || bus.Time_mem !== 11'd360) begin
            n_bad++; $display("FAIL areset_data got stu=%0d seat=%0d ban=%0d time=%0d want 0/0/2/360",
                              bus.Student_No_mem, bus.Seat_No_mem, bus.ban_mem, bus.Time_mem); end
        bus.kreq_arb = 4'd0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (bus.kack_arb !== 4'd0 || bus.write_mem !== 1'b0) extra++;
        end
        n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL areset_no_ack got %0d active cycles want 0", extra); end
    endtask

    task automatic test_day_wrap;
        int          wraps, rst_hi, rst_first, strobe_k, ack_k, strobe_in_rst;
        logic [10:0] prev;
        do_reset();
        bus.kstu_arb[3]   = 32'd777;
        bus.kseat_arb[3]  = 5'd31;
        bus.kstate_arb[3] = 2'd3;
        wraps = 0; rst_hi = 0; rst_first = -1; strobe_k = -1; ack_k = -1; strobe_in_rst = 0;
        prev = bus.Time_mem;
        for (int k = 1; k <= 5772; k++) begin
            step();
            if (prev == 11'd1439 && bus.Time_mem == 11'd0) wraps++;
            prev = bus.Time_mem;
            if (bus.rst_mem === 1'b1) begin
                rst_hi++;
                if (rst_first < 0) rst_first = k;
                if (bus.write_mem === 1'b1) strobe_in_rst++;
            end
            if (k == 4319) begin
                n_cmp++; if (bus.Time_mem !== 11'd1439) begin n_bad++; $display("FAIL day_1439 got %0d want 1439", bus.Time_mem); end
            end
            if (k == 4320) begin
                n_cmp++; if (bus.Time_mem !== 11'd0) begin n_bad++; $display("FAIL day_wrap0 got %0d want 0", bus.Time_mem); end
            end
            if (k == 5760) begin
                n_cmp++; if (bus.Time_mem !== 11'd360 || bus.rst_mem !== 1'b0) begin
                    n_bad++; $display("FAIL day_back360 got time=%0d rst=%0h want 360/0", bus.Time_mem, bus.rst_mem); end
            end
            if (bus.write_mem === 1'b1 && strobe_k < 0) strobe_k = k;
            if (bus.kack_arb[3] === 1'b1) begin
                ack_k = k;
                bus.kreq_arb[3] = 1'b0;
            end
            if (k == 5761) bus.kreq_arb[3] = 1'b1;
        end
        bus.kreq_arb = 4'd0;
        n_cmp++; if (wraps !== 1) begin n_bad++; $display("FAIL day_wrap_count got %0d want 1", wraps); end
        n_cmp++; if (rst_first !== 5761) begin n_bad++; $display("FAIL day_rst_start got %0d want 5761", rst_first); end
        n_cmp++; if (rst_hi !== 2) begin n_bad++; $display("FAIL day_rst_len got %0d want 2", rst_hi); end
        n_cmp++; if (strobe_in_rst !== 0) begin n_bad++; $display("FAIL open_strobe_in_rst got %0d want 0", strobe_in_rst); end
        n_cmp++; if (strobe_k !== 5765) begin n_bad++; $display("FAIL open_strobe_cycle got %0d want 5765", strobe_k); end
        n_cmp++; if (ack_k !== 5766) begin n_bad++; $display("FAIL open_ack_cycle got %0d want 5766", ack_k); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_single_kiosk();
        test_contention();
        test_manager_priority();
        test_bad_op();
        test_drop_after_grant();
        test_async_reset();
        test_day_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seat_req_arbiter.md
SEAT_REQ_ARBITER -- requirements
Module: seat_req_arbiter

Interface
REQ-001 SHALL have parameter TICKS_PER_MIN, default 60, clock cycles per simulated minute (≥4).
REQ-002 SHALL have parameter OPEN_MIN, default 360, minute-of-day at which the daily reset fires (06:00).
REQ-003 SHALL have port clk_arb input 1, single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n_arb input 1, asynchronous active-low reset.
REQ-005 SHALL have ports kreq_arb[k] input 1, k=0..3, kiosk k request, level, held until ack.
REQ-006 SHALL have ports kstu_arb[k] input 32, kseat_arb[k] input 5, kstate_arb[k] input 2, kiosk k student number, seat index and requested state, stable while kreq_arb[k]=1.
REQ-007 SHALL have port kack_arb output 4, one-cycle acknowledge per kiosk.
REQ-008 SHALL have ports mreq_arb input 1, mop_arb input 2 (1=ban set, 2=limit set), mban_arb input 2, mlimit_arb input 11, manager request and payload.
REQ-009 SHALL have port mack_arb output 1, one-cycle manager acknowledge.
REQ-010 SHALL have ports write_mem output 1, Student_No_mem output 32, Seat_No_mem output 5, Seat_State_mem output 2, write_set_mem output 2, ban_mem output 2, limit_time_mem output 11, rst_mem output 1, Time_mem output 11, driving the seat memory.

Function
REQ-011 SHALL count cycles 0..TICKS_PER_MIN-1; at terminal count Time_mem increments, wrapping 1439->0.
REQ-012 SHALL assert rst_mem for exactly 2 cycles starting the cycle after Time_mem becomes OPEN_MIN.
REQ-013 SHALL implement FSM IDLE -> SETUP -> STROBE -> RELEASE -> IDLE, one cycle each except IDLE.
REQ-014 IDLE: if rst_mem=0 and any request pending, SHALL latch winner payload onto memory outputs and go SETUP; else stay.
REQ-015 Arbitration: mreq_arb SHALL beat all kiosks; among kiosks, round-robin starting from the index after the last granted kiosk (pointer init 0, manager grants do not move it).
REQ-016 SETUP: payload outputs stable, write_mem=0, write_set_mem=0.
REQ-017 STROBE (kiosk grant): write_mem=1 for exactly one cycle; write_set_mem=0.
REQ-018 STROBE (manager grant): write_set_mem=mop_arb latched for exactly one cycle; write_mem=0.
REQ-019 RELEASE: write_mem=0, write_set_mem=0, payload still held; kack_arb[winner] or mack_arb=1 for this cycle only.
REQ-020 Latency: request seen in IDLE at cycle t -> strobe at t+2, ack at t+3, next grant earliest t+4.
REQ-021 A request dropped before grant SHALL be ignored; one dropped after grant SHALL still complete its sequence.
REQ-022 rst_mem rising while FSM not IDLE SHALL not abort the sequence; no new grant while rst_mem=1.
REQ-023 Manager mop_arb of 0 or 3 SHALL be acked in RELEASE with no strobe.
REQ-024 ban_mem and limit_time_mem SHALL hold last manager-written values between manager grants; Student_No_mem, Seat_No_mem, Seat_State_mem SHALL hold last kiosk values.
REQ-025 Minute tick coinciding with STROBE SHALL be accepted; Time_mem changes independently of FSM.

Reset
REQ-026 rst_n_arb=0 SHALL asynchronously force FSM IDLE, tick counter 0, Time_mem=OPEN_MIN, RR pointer 0.
REQ-027 During reset: write_mem=0, write_set_mem=0, kack_arb=0, mack_arb=0, rst_mem=0, Student_No_mem=0, Seat_No_mem=0, Seat_State_mem=0, ban_mem=2, limit_time_mem=120.
REQ-028 Reset asserted mid-sequence SHALL drop the in-flight request with no ack.

Verification
REQ-029 Single kiosk: kreq[2]=1, stu=20230001, seat=5, state=2 -> write_mem pulse 2 cycles later with those values, kack[2] next cycle.
REQ-030 Contention: kreq[0..3] all high continuously -> grant order 0,1,2,3,0; each strobe 4 cycles apart.
REQ-031 Manager priority: mreq and kreq[1] same cycle, mop=1, mban=0 -> write_set_mem=1 with ban_mem=0 first, kiosk 1 strobe 4 cycles later.
REQ-032 Clock: TICKS_PER_MIN=4, from reset run 1440*4 cycles -> Time_mem wraps 1439->0 once and returns to 360; rst_mem high 2 cycles at the 360 tick.
REQ-033 Open overlap: kreq pending when rst_mem rises -> no strobe during rst_mem; strobe 2 cycles after rst_mem falls.
REQ-034 Async reset in STROBE -> write_mem=0 immediately, no ack, outputs at reset values.
